// File: rtl/pid_controller_pipe.sv
// Four-state pipelined signed PID controller with anti-windup, clamping and manual override.
// Optional derivative IIR filter enabled by defining PID_DERIV_FILTER_EN.
module pid_controller_pipe #(
  parameter int DW   = 16,
  parameter int CW   = 16,
  parameter int FRAC = 8,
  parameter int IW   = 24,
  parameter int OW   = 16,
  parameter int DFS  = 3
) (
  input  logic          clk_in_i,
  input  logic          reset_i,
  input  logic          sample_valid_i,
  output logic          sample_ready_o,
  input  logic [DW-1:0] sp_i,
  input  logic [DW-1:0] meas_i,
  input  logic [CW-1:0] kp_i,
  input  logic [CW-1:0] ki_i,
  input  logic [CW-1:0] kd_i,
  input  logic [OW-1:0] offset_i,
  input  logic [IW-1:0] int_hi_i,
  input  logic [IW-1:0] int_lo_i,
  input  logic [OW-1:0] out_hi_i,
  input  logic [OW-1:0] out_lo_i,
  input  logic          man_control_i,
  input  logic [OW-1:0] man_value_i,
  output logic [OW-1:0] pid_o,
  output logic          pid_valid_o,
  output logic [1:0]    sat_o,
  output logic [DW:0]   err_o,
  output logic [IW-1:0] int_o
);

  localparam int EW  = DW + 1;
  localparam int DDW = DW + 2;
  localparam int PW  = CW + IW + 1;
  localparam int SW  = PW + 2;
  localparam int IW1 = IW + 1;

  typedef enum logic [1:0] {IDLE, ERR, MUL, SUM} state_t;
  state_t state_q, state_d;

  logic signed [DW-1:0]  sp_q, meas_q;
  logic signed [CW-1:0]  kp_q, ki_q, kd_q;
  logic signed [OW-1:0]  offset_q, out_hi_q, out_lo_q, man_value_q, pid_q;
  logic signed [IW-1:0]  int_hi_q, int_lo_q, integ_q;
  logic                  man_q, first_q, pid_valid_q;
  logic [1:0]            sat_q;
  logic signed [EW-1:0]  e_q, prev_e_q, e_c;
  logic signed [DDW-1:0] d_q, d_raw_c, d_sel_c;
  logic signed [PW-1:0]  p_prod_q, i_prod_q, d_prod_q;

  logic signed [SW-1:0]  sum_c, cmd_c, hi_x, lo_x, out_step_c, out_clamp_c;
  logic                  out_sat_hi_c, out_sat_lo_c;
  logic signed [IW1-1:0] isum_c, ihi_x, ilo_x, int_step_c, int_clamp_c;
  logic                  e_pos, e_neg, windup_hold;

`ifdef PID_DERIV_FILTER_EN
  logic signed [DDW-1:0] df_q, df_n;
  logic signed [DDW:0]   df_diff;
`endif

  always_ff @(posedge clk_in_i) begin
    if (reset_i) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d        = state_q;
    sample_ready_o = 1'b0;
    case (state_q)
      IDLE: begin
        sample_ready_o = 1'b1;
        if (sample_valid_i) state_d = ERR;
      end
      ERR:     state_d = MUL;
      MUL:     state_d = SUM;
      SUM:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The first sample after reset has no previous error, so its derivative is forced to 0.
  always_comb begin
    e_c     = sp_q - meas_q;
    d_raw_c = '0;
    if (!first_q) d_raw_c = DDW'(e_c) - DDW'(prev_e_q);
`ifdef PID_DERIV_FILTER_EN
    df_diff = (DDW+1)'(d_raw_c) - (DDW+1)'(df_q);
    df_n    = df_q + DDW'(df_diff >>> DFS);
    d_sel_c = man_q ? df_q : df_n;
`else
    d_sel_c = d_raw_c;
`endif
  end

  // Both clamps test the upper bound first, so the lower bound wins when lo > hi.
  always_comb begin
    sum_c        = SW'(p_prod_q) + SW'(i_prod_q) + SW'(d_prod_q);
    cmd_c        = man_q ? SW'(man_value_q) : (sum_c >>> FRAC) + SW'(offset_q);
    hi_x         = SW'(out_hi_q);
    lo_x         = SW'(out_lo_q);
    out_sat_hi_c = cmd_c > hi_x;
    out_step_c   = out_sat_hi_c ? hi_x : cmd_c;
    out_sat_lo_c = out_step_c < lo_x;
    out_clamp_c  = out_sat_lo_c ? lo_x : out_step_c;

    isum_c      = IW1'(integ_q) + IW1'(e_q);
    ihi_x       = IW1'(int_hi_q);
    ilo_x       = IW1'(int_lo_q);
    int_step_c  = (isum_c > ihi_x) ? ihi_x : isum_c;
    int_clamp_c = (int_step_c < ilo_x) ? ilo_x : int_step_c;

    e_pos       = ~e_q[EW-1] & (|e_q);
    e_neg       = e_q[EW-1];
    windup_hold = (sat_q[1] & e_pos) | (sat_q[0] & e_neg);
  end

  always_ff @(posedge clk_in_i) begin
    if (reset_i) begin
      sp_q        <= '0;
      meas_q      <= '0;
      kp_q        <= '0;
      ki_q        <= '0;
      kd_q        <= '0;
      offset_q    <= '0;
      out_hi_q    <= '0;
      out_lo_q    <= '0;
      man_value_q <= '0;
      int_hi_q    <= '0;
      int_lo_q    <= '0;
      man_q       <= 1'b0;
      first_q     <= 1'b1;
      e_q         <= '0;
      prev_e_q    <= '0;
      d_q         <= '0;
      p_prod_q    <= '0;
      i_prod_q    <= '0;
      d_prod_q    <= '0;
      integ_q     <= '0;
      pid_q       <= '0;
      sat_q       <= 2'b00;
      pid_valid_q <= 1'b0;
`ifdef PID_DERIV_FILTER_EN
      df_q        <= '0;
`endif
    end else begin
      pid_valid_q <= 1'b0;
      case (state_q)
        IDLE: if (sample_valid_i) begin
          sp_q        <= sp_i;
          meas_q      <= meas_i;
          kp_q        <= kp_i;
          ki_q        <= ki_i;
          kd_q        <= kd_i;
          offset_q    <= offset_i;
          out_hi_q    <= out_hi_i;
          out_lo_q    <= out_lo_i;
          int_hi_q    <= int_hi_i;
          int_lo_q    <= int_lo_i;
          man_q       <= man_control_i;
          man_value_q <= man_value_i;
        end
        ERR: begin
          e_q     <= e_c;
          d_q     <= d_sel_c;
          first_q <= 1'b0;
`ifdef PID_DERIV_FILTER_EN
          df_q    <= d_sel_c;
`endif
        end
        MUL: begin
          p_prod_q <= PW'(kp_q) * PW'(e_q);
          i_prod_q <= PW'(ki_q) * PW'(integ_q);
          d_prod_q <= PW'(kd_q) * PW'(d_q);
        end
        SUM: begin
          pid_q       <= OW'(out_clamp_c);
          sat_q       <= {out_sat_hi_c, out_sat_lo_c};
          prev_e_q    <= e_q;
          pid_valid_q <= 1'b1;
          if (!man_q && !windup_hold) integ_q <= IW'(int_clamp_c);
        end
        default: ;
      endcase
    end
  end

  assign pid_o       = pid_q;
  assign pid_valid_o = pid_valid_q;
  assign sat_o       = sat_q;
  assign err_o       = e_q;
  assign int_o       = integ_q;

endmodule

// File: tb/tb_pid_controller_pipe.sv
// Directed-vector bench for pid_controller_pipe (default build, derivative filter off).
module tb_pid_controller_pipe;

  logic        clk_in_i = 1'b0;
  logic        reset_i = 1'b1;
  logic        sample_valid_i = 1'b0;
  logic        sample_ready_o;
  logic [15:0] sp_i, meas_i, kp_i, ki_i, kd_i, offset_i, out_hi_i, out_lo_i, man_value_i;
  logic [23:0] int_hi_i, int_lo_i;
  logic        man_control_i;
  logic [15:0] pid_o;
  logic        pid_valid_o;
  logic [1:0]  sat_o;
  logic [16:0] err_o;
  logic [23:0] int_o;

  int total = 0;
  int bad = 0;

  pid_controller_pipe dut (
    .clk_in_i(clk_in_i), .reset_i(reset_i),
    .sample_valid_i(sample_valid_i), .sample_ready_o(sample_ready_o),
    .sp_i(sp_i), .meas_i(meas_i), .kp_i(kp_i), .ki_i(ki_i), .kd_i(kd_i),
    .offset_i(offset_i), .int_hi_i(int_hi_i), .int_lo_i(int_lo_i),
    .out_hi_i(out_hi_i), .out_lo_i(out_lo_i),
    .man_control_i(man_control_i), .man_value_i(man_value_i),
    .pid_o(pid_o), .pid_valid_o(pid_valid_o), .sat_o(sat_o),
    .err_o(err_o), .int_o(int_o)
  );

  always #5 clk_in_i = ~clk_in_i;

  task automatic set_defaults();
    sp_i = '0; meas_i = '0; kp_i = '0; ki_i = '0; kd_i = '0; offset_i = '0;
    out_hi_i = 16'h7FFF; out_lo_i = 16'h8000;
    int_hi_i = 24'h7FFFFF; int_lo_i = 24'h800000;
    man_control_i = 1'b0; man_value_i = '0;
  endtask

  task automatic do_reset();
    @(negedge clk_in_i);
    reset_i = 1'b1; sample_valid_i = 1'b0;
    repeat (2) @(posedge clk_in_i);
    #1 reset_i = 1'b0;
  endtask

  // Hands one sample over and returns the cycles from handshake to pid_valid_o (-1 if none).
  task automatic drive_sample(input int sp, input int meas, output int lat);
    @(negedge clk_in_i);
    sp_i = 16'(sp); meas_i = 16'(meas); sample_valid_i = 1'b1;
    lat = -1;
    for (int k = 0; k < 8 && !sample_ready_o; k++) @(negedge clk_in_i);
    @(posedge clk_in_i);
    #1 sample_valid_i = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk_in_i);
      #1;
      if (pid_valid_o) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (sample_ready_o !== 1'b1) begin bad++; $display("[TB] FAIL reset_ready got=%b want=1", sample_ready_o); end
    total++; if (pid_valid_o !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid got=%b want=0", pid_valid_o); end
    total++; if (pid_o !== 16'd0) begin bad++; $display("[TB] FAIL reset_pid got=%0d want=0", $signed(pid_o)); end
    total++; if (sat_o !== 2'b00) begin bad++; $display("[TB] FAIL reset_sat got=%b want=00", sat_o); end
    total++; if (err_o !== 17'd0) begin bad++; $display("[TB] FAIL reset_err got=%0d want=0", $signed(err_o)); end
    total++; if (int_o !== 24'd0) begin bad++; $display("[TB] FAIL reset_int got=%0d want=0", $signed(int_o)); end
  endtask

  task automatic test_p_term();
    int lat;
    set_defaults();
    kp_i = 16'd256;
    drive_sample(100, 40, lat);
    total++; if (lat != 3) begin bad++; $display("[TB] FAIL p_latency got=%0d want=3", lat); end
    total++; if (pid_o !== 16'd60) begin bad++; $display("[TB] FAIL p_pid got=%0d want=60", $signed(pid_o)); end
    total++; if (sat_o !== 2'b00) begin bad++; $display("[TB] FAIL p_sat got=%b want=00", sat_o); end
    total++; if (err_o !== 17'd60) begin bad++; $display("[TB] FAIL p_err got=%0d want=60", $signed(err_o)); end
  endtask

  task automatic test_rounding();
    int lat;
    set_defaults();
    kp_i = 16'd128;
    drive_sample(0, 3, lat);
    total++; if (pid_o !== 16'(-2)) begin bad++; $display("[TB] FAIL round_neg got=%0d want=-2", $signed(pid_o)); end
    offset_i = 16'd10;
    drive_sample(0, 3, lat);
    total++; if (pid_o !== 16'd8) begin bad++; $display("[TB] FAIL round_offset got=%0d want=8", $signed(pid_o)); end
    drive_sample(3, 0, lat);
    total++; if (pid_o !== 16'd11) begin bad++; $display("[TB] FAIL round_pos got=%0d want=11", $signed(pid_o)); end
  endtask

  task automatic test_saturation();
    int lat;
    do_reset();
    set_defaults();
    kp_i = 16'd1024; ki_i = 16'd256; out_hi_i = 16'd2000;
    drive_sample(1000, 0, lat);
    total++; if (pid_o !== 16'd2000) begin bad++; $display("[TB] FAIL sat1_pid got=%0d want=2000", $signed(pid_o)); end
    total++; if (sat_o !== 2'b10) begin bad++; $display("[TB] FAIL sat1_flags got=%b want=10", sat_o); end
    total++; if (int_o !== 24'd1000) begin bad++; $display("[TB] FAIL sat1_int got=%0d want=1000", $signed(int_o)); end
    drive_sample(1000, 0, lat);
    total++; if (pid_o !== 16'd2000) begin bad++; $display("[TB] FAIL sat2_pid got=%0d want=2000", $signed(pid_o)); end
    total++; if (int_o !== 24'd1000) begin bad++; $display("[TB] FAIL sat2_int_frozen got=%0d want=1000", $signed(int_o)); end
    out_hi_i = 16'd100; out_lo_i = 16'd200;
    drive_sample(1000, 0, lat);
    total++; if (pid_o !== 16'd200) begin bad++; $display("[TB] FAIL order_pid got=%0d want=200", $signed(pid_o)); end
    total++; if (sat_o !== 2'b11) begin bad++; $display("[TB] FAIL order_flags got=%b want=11", sat_o); end
    total++; if (int_o !== 24'd1000) begin bad++; $display("[TB] FAIL order_int got=%0d want=1000", $signed(int_o)); end
  endtask

  task automatic test_integrator();
    int lat, exp_int, exp_pid;
    do_reset();
    set_defaults();
    ki_i = 16'd256; int_hi_i = 24'd300;
    for (int k = 1; k <= 10; k++) begin
      drive_sample(50, 0, lat);
      exp_int = (50 * k > 300) ? 300 : 50 * k;
      exp_pid = (50 * (k - 1) > 300) ? 300 : 50 * (k - 1);
      total++; if (int_o !== 24'(exp_int)) begin bad++; $display("[TB] FAIL int_up%0d got=%0d want=%0d", k, $signed(int_o), exp_int); end
      total++; if (pid_o !== 16'(exp_pid)) begin bad++; $display("[TB] FAIL int_pid%0d got=%0d want=%0d", k, $signed(pid_o), exp_pid); end
    end
    drive_sample(0, 50, lat);
    total++; if (int_o !== 24'd250) begin bad++; $display("[TB] FAIL int_down1 got=%0d want=250", $signed(int_o)); end
    total++; if (pid_o !== 16'd300) begin bad++; $display("[TB] FAIL int_down1_pid got=%0d want=300", $signed(pid_o)); end
    drive_sample(0, 50, lat);
    total++; if (int_o !== 24'd200) begin bad++; $display("[TB] FAIL int_down2 got=%0d want=200", $signed(int_o)); end
    int_lo_i = 24'd150;
    drive_sample(0, 50, lat);
    total++; if (int_o !== 24'd150) begin bad++; $display("[TB] FAIL int_lo1 got=%0d want=150", $signed(int_o)); end
    drive_sample(0, 50, lat);
    total++; if (int_o !== 24'd150) begin bad++; $display("[TB] FAIL int_lo2 got=%0d want=150", $signed(int_o)); end
    total++; if (pid_o !== 16'd150) begin bad++; $display("[TB] FAIL int_lo2_pid got=%0d want=150", $signed(pid_o)); end
  endtask

  task automatic test_derivative();
    int lat;
    do_reset();
    set_defaults();
    kd_i = 16'd256;
    drive_sample(0, 0, lat);
    total++; if (pid_o !== 16'd0) begin bad++; $display("[TB] FAIL deriv1 got=%0d want=0", $signed(pid_o)); end
    drive_sample(0, 10, lat);
    total++; if (pid_o !== 16'(-10)) begin bad++; $display("[TB] FAIL deriv2 got=%0d want=-10", $signed(pid_o)); end
    total++; if (err_o !== 17'(-10)) begin bad++; $display("[TB] FAIL deriv2_err got=%0d want=-10", $signed(err_o)); end
    drive_sample(0, 10, lat);
    total++; if (pid_o !== 16'd0) begin bad++; $display("[TB] FAIL deriv3 got=%0d want=0", $signed(pid_o)); end
    do_reset();
    drive_sample(0, 10, lat);
    total++; if (pid_o !== 16'd0) begin bad++; $display("[TB] FAIL deriv_first got=%0d want=0", $signed(pid_o)); end
  endtask

  task automatic test_manual();
    int lat;
    do_reset();
    set_defaults();
    kp_i = 16'd256; ki_i = 16'd256; kd_i = 16'd256; out_lo_i = 16'(-400);
    drive_sample(0, 20, lat);
    total++; if (pid_o !== 16'(-20)) begin bad++; $display("[TB] FAIL man_pre_pid got=%0d want=-20", $signed(pid_o)); end
    total++; if (int_o !== 24'(-20)) begin bad++; $display("[TB] FAIL man_pre_int got=%0d want=-20", $signed(int_o)); end
    man_control_i = 1'b1; man_value_i = 16'(-500);
    drive_sample(0, 50, lat);
    total++; if (pid_o !== 16'(-400)) begin bad++; $display("[TB] FAIL man_pid got=%0d want=-400", $signed(pid_o)); end
    total++; if (sat_o !== 2'b01) begin bad++; $display("[TB] FAIL man_sat got=%b want=01", sat_o); end
    total++; if (int_o !== 24'(-20)) begin bad++; $display("[TB] FAIL man_int got=%0d want=-20", $signed(int_o)); end
    man_control_i = 1'b0;
    drive_sample(0, 50, lat);
    total++; if (pid_o !== 16'(-70)) begin bad++; $display("[TB] FAIL man_return_pid got=%0d want=-70", $signed(pid_o)); end
    total++; if (sat_o !== 2'b00) begin bad++; $display("[TB] FAIL man_return_sat got=%b want=00", sat_o); end
    total++; if (int_o !== 24'(-20)) begin bad++; $display("[TB] FAIL man_return_int got=%0d want=-20", $signed(int_o)); end
  endtask

  task automatic test_reset_mid();
    int lat, seen;
    do_reset();
    set_defaults();
    kp_i = 16'd256;
    drive_sample(100, 40, lat);
    total++; if (pid_o !== 16'd60) begin bad++; $display("[TB] FAIL mid_pre got=%0d want=60", $signed(pid_o)); end
    @(negedge clk_in_i);
    sp_i = 16'd100; meas_i = 16'd0; sample_valid_i = 1'b1;
    @(posedge clk_in_i);
    #1 sample_valid_i = 1'b0;
    @(posedge clk_in_i);
    #1 reset_i = 1'b1;
    @(posedge clk_in_i);
    #1 reset_i = 1'b0;
    total++; if (sample_ready_o !== 1'b1) begin bad++; $display("[TB] FAIL mid_ready got=%b want=1", sample_ready_o); end
    total++; if (pid_o !== 16'd0) begin bad++; $display("[TB] FAIL mid_pid got=%0d want=0", $signed(pid_o)); end
    seen = 0;
    for (int k = 0; k < 5; k++) begin
      if (pid_valid_o) seen++;
      @(posedge clk_in_i);
      #1;
    end
    total++; if (seen != 0) begin bad++; $display("[TB] FAIL mid_no_valid got=%0d want=0", seen); end
  endtask

  task automatic test_back_to_back();
    int seen;
    set_defaults();
    kp_i = 16'd256;
    @(negedge clk_in_i);
    sp_i = 16'd100; meas_i = 16'd40; sample_valid_i = 1'b1;
    @(posedge clk_in_i);
    #1 meas_i = 16'd0; kp_i = 16'd512;
    total++; if (sample_ready_o !== 1'b0) begin bad++; $display("[TB] FAIL busy_ready1 got=%b want=0", sample_ready_o); end
    @(posedge clk_in_i);
    #1;
    total++; if (sample_ready_o !== 1'b0) begin bad++; $display("[TB] FAIL busy_ready2 got=%b want=0", sample_ready_o); end
    @(posedge clk_in_i);
    #1;
    total++; if (pid_valid_o !== 1'b0) begin bad++; $display("[TB] FAIL busy_early_valid got=%b want=0", pid_valid_o); end
    @(posedge clk_in_i);
    #1 sample_valid_i = 1'b0;
    total++; if (pid_valid_o !== 1'b1) begin bad++; $display("[TB] FAIL busy_valid got=%b want=1", pid_valid_o); end
    total++; if (pid_o !== 16'd60) begin bad++; $display("[TB] FAIL busy_pid got=%0d want=60", $signed(pid_o)); end
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk_in_i);
      #1;
      if (pid_valid_o) seen++;
    end
    total++; if (seen != 0) begin bad++; $display("[TB] FAIL busy_extra_valid got=%0d want=0", seen); end
  endtask

  initial begin
    set_defaults();
    test_reset();
    test_p_term();
    test_rounding();
    test_saturation();
    test_integrator();
    test_derivative();
    test_manual();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
